// File: rtl/mux_4x1_arbiter.sv
// Round-robin owner arbiter for a shared 4x1 mux path: IDLE -> GRANT -> RELEASE, hold limited to HOLD_MAX cycles.
// Grant 1 cycle after req sampled; all outputs registered; no preemption, owner releases by dropping req or by timeout.
module mux_4x1_arbiter #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] select,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   state_t     state_q, state_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [1:0] last_q, last_d;
   logic [3:0] gnt_d;
   logic [1:0] select_d;
   logic       busy_d;
   logic       timeout_d;
   logic       win_vld;
   logic [1:0] win_idx;
   logic [1:0] cand;

   // Scan from the farthest offset down so the nearest requester after last_q wins.
   always_comb begin
      win_vld = 1'b0;
      win_idx = 2'd0;
      cand    = last_q;
      for (int i = 4; i >= 1; i--) begin
         cand = last_q + 2'(i);
         if (req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      last_d     = last_q;
      gnt_d      = gnt;
      select_d   = select;
      busy_d     = busy;
      timeout_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d    = GRANT;
               gnt_d      = 4'b0001 << win_idx;
               select_d   = win_idx;
               busy_d     = 1'b1;
               hold_cnt_d = 8'd0;
            end else begin
               gnt_d  = 4'b0000;
               busy_d = 1'b0;
            end
         end
         GRANT: begin
            // A voluntary drop wins over the timeout when both land on the same cycle.
            if (!req[select]) begin
               state_d = RELEASE;
               gnt_d   = 4'b0000;
               last_d  = select;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d   = RELEASE;
               gnt_d     = 4'b0000;
               last_d    = select;
               timeout_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         RELEASE: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         hold_cnt_q <= 8'd0;
         last_q     <= 2'b11;
         gnt        <= 4'b0000;
         select     <= 2'b00;
         busy       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         last_q     <= last_d;
         gnt        <= gnt_d;
         select     <= select_d;
         busy       <= busy_d;
         timeout    <= timeout_d;
      end
   end

endmodule

// File: tb/tb_mux_4x1_arbiter.sv
// Bench for mux_4x1_arbiter: directed scenarios plus random request traffic against a cycle-level reference model.
module tb_mux_4x1_arbiter;

   localparam int HOLD_MAX = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req   = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] select;
   logic       busy;
   logic       timeout;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: phase 0 idle, 1 owner holds the path, 2 turnaround.
   int         m_phase;
   int         m_owner;
   int         m_last;
   int         m_held;
   logic [3:0] m_gnt;
   logic [1:0] m_sel;
   logic       m_busy;
   logic       m_to;

   mux_4x1_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .select  (select),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      vectors++;
      if (!$onehot0(gnt)) begin
         miscompares++;
         $display("FAIL onehot: gnt=%b has more than one bit set", gnt);
      end
   end

   task automatic model_reset();
      m_phase = 0;
      m_owner = 0;
      m_last  = 3;
      m_held  = 0;
      m_gnt   = 4'b0000;
      m_sel   = 2'd0;
      m_busy  = 1'b0;
      m_to    = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] r);
      m_to = 1'b0;
      if (m_phase == 0) begin
         if (r != 4'b0000) begin
            for (int k = 4; k >= 1; k--)
               if (r[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
            m_phase = 1;
            m_held  = 1;
            m_gnt   = 4'(1 << m_owner);
            m_sel   = 2'(m_owner);
            m_busy  = 1'b1;
         end else begin
            m_gnt  = 4'b0000;
            m_busy = 1'b0;
         end
      end else if (m_phase == 1) begin
         if (!r[m_owner] || m_held == HOLD_MAX) begin
            m_to    = r[m_owner];
            m_phase = 2;
            m_gnt   = 4'b0000;
            m_last  = m_owner;
         end else begin
            m_held++;
         end
      end else begin
         m_phase = 0;
         m_gnt   = 4'b0000;
         m_busy  = 1'b0;
      end
   endtask

   task automatic cycle(input logic [3:0] r, input string tag);
      req = r;
      @(posedge clk);
      model_step(r);
      #1;
      vectors++;
      if ({gnt, select, busy, timeout} !== {m_gnt, m_sel, m_busy, m_to}) begin
         miscompares++;
         $display("FAIL %s: got gnt=%b sel=%0d busy=%b to=%b, expected gnt=%b sel=%0d busy=%b to=%b",
                  tag, gnt, select, busy, timeout, m_gnt, m_sel, m_busy, m_to);
      end
   endtask

   // Asserts reset between edges, checks outputs cleared without a clock, releases before the next edge.
   task automatic do_reset(input string tag);
      req = 4'b0000;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if ({gnt, select, busy, timeout} !== 8'b0000_00_0_0) begin
         miscompares++;
         $display("FAIL %s: got gnt=%b sel=%0d busy=%b to=%b, expected all zero",
                  tag, gnt, select, busy, timeout);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset("reset_values");
      cycle(4'b0000, "reset_idle");
      cycle(4'b0000, "reset_idle2");
   endtask

   task automatic test_round_robin();
      int order[$];
      int gaps[$];
      int zeros;
      logic [3:0] prev;
      do_reset("rr_reset");
      zeros = 0;
      prev  = 4'b0000;
      for (int i = 0; i < 26; i++) begin
         cycle(4'b1111, "rr_cycle");
         if (gnt != 4'b0000 && prev == 4'b0000) begin
            order.push_back(int'(select));
            gaps.push_back(zeros);
         end
         if (gnt == 4'b0000) zeros++;
         else zeros = 0;
         prev = gnt;
      end
      vectors++;
      if (order.size() < 5) begin
         miscompares++;
         $display("FAIL rr_count: got %0d grants, expected at least 5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (order[i] != (i % 4)) begin
               miscompares++;
               $display("FAIL rr_order[%0d]: got owner %0d, expected %0d", i, order[i], i % 4);
            end
            if (i > 0) begin
               vectors++;
               if (gaps[i] != 2) begin
                  miscompares++;
                  $display("FAIL rr_gap[%0d]: got %0d idle cycles, expected 2", i, gaps[i]);
               end
            end
         end
      end
   endtask

   task automatic test_single_grant();
      int to_seen;
      do_reset("single_reset");
      to_seen = 0;
      cycle(4'b0100, "single_c1");
      vectors++;
      if (gnt !== 4'b0100 || select !== 2'd2) begin
         miscompares++;
         $display("FAIL single_first: got gnt=%b sel=%0d, expected gnt=0100 sel=2", gnt, select);
      end
      cycle(4'b0100, "single_c2");
      cycle(4'b0100, "single_c3");
      for (int i = 0; i < 3; i++) begin
         cycle(4'b0000, "single_tail");
         if (timeout) to_seen++;
      end
      vectors++;
      if (to_seen != 0) begin
         miscompares++;
         $display("FAIL single_timeout: got %0d timeout pulses, expected 0", to_seen);
      end
   endtask

   task automatic test_timeout();
      int g_cnt;
      int t_cnt;
      do_reset("timeout_reset");
      g_cnt = 0;
      t_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(4'b0010, "timeout_cycle");
         if (gnt[1]) g_cnt++;
         if (timeout) t_cnt++;
      end
      cycle(4'b0010, "timeout_regrant");
      vectors++;
      if (g_cnt != HOLD_MAX || t_cnt != 1) begin
         miscompares++;
         $display("FAIL timeout_counts: got %0d grant cycles %0d pulses, expected %0d and 1",
                  g_cnt, t_cnt, HOLD_MAX);
      end
      vectors++;
      if (gnt !== 4'b0010) begin
         miscompares++;
         $display("FAIL timeout_regrant_gnt: got %b, expected 0010", gnt);
      end
      cycle(4'b0000, "timeout_drop");
   endtask

   task automatic test_no_preempt();
      do_reset("preempt_reset");
      cycle(4'b0100, "preempt_grant");
      cycle(4'b1101, "preempt_hold1");
      vectors++;
      if (gnt !== 4'b0100) begin
         miscompares++;
         $display("FAIL preempt_hold: got gnt=%b, expected 0100", gnt);
      end
      cycle(4'b1101, "preempt_hold2");
      cycle(4'b1001, "preempt_release");
      cycle(4'b1001, "preempt_idle");
      cycle(4'b1001, "preempt_next");
      vectors++;
      if (gnt !== 4'b1000 || select !== 2'd3) begin
         miscompares++;
         $display("FAIL preempt_winner: got gnt=%b sel=%0d, expected 1000 sel=3", gnt, select);
      end
      cycle(4'b0000, "preempt_drop");
   endtask

   task automatic test_coincide();
      do_reset("coincide_reset");
      for (int i = 0; i < HOLD_MAX; i++) cycle(4'b0001, "coincide_hold");
      cycle(4'b0000, "coincide_release");
      vectors++;
      if (timeout !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL coincide_release: got to=%b gnt=%b busy=%b, expected to=0 gnt=0000 busy=1",
                  timeout, gnt, busy);
      end
      cycle(4'b0000, "coincide_idle");
   endtask

   task automatic test_reset_mid_grant();
      do_reset("midrst_pre");
      cycle(4'b0100, "midrst_grant");
      cycle(4'b0100, "midrst_hold");
      do_reset("midrst_async");
      cycle(4'b1010, "midrst_after");
      vectors++;
      if (gnt !== 4'b0010) begin
         miscompares++;
         $display("FAIL midrst_winner: got gnt=%b, expected 0010", gnt);
      end
      cycle(4'b0000, "midrst_drop");
   endtask

   task automatic test_random();
      logic [3:0] r;
      do_reset("random_reset");
      r = 4'b0000;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         cycle(r, "random");
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_round_robin();
      test_single_grant();
      test_timeout();
      test_no_preempt();
      test_coincide();
      test_reset_mid_grant();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mux_4x1_arbiter.md
MUX_4X1_ARBITER -- requirements
Module: mux_4x1_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 15: the maximum number of consecutive GRANT cycles one owner may hold the shared 4x1 mux path; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req  input  [3:0]  request from requester i, level-sensitive; held high for the whole use of the mux path.
REQ-005 gnt  output  [3:0]  one-hot grant to the current owner; all zero when there is no owner.
REQ-006 select  output  [1:0]  mux select; drives the 4x1 mux select input directly and equals the index of the owner.
REQ-007 busy  output  1  high while in GRANT or RELEASE.
REQ-008 timeout  output  1  one-cycle pulse when an owner is forcibly released.

Function
REQ-009 The block SHALL implement three states: IDLE, GRANT and RELEASE, encoded in registered state.
REQ-010 All outputs SHALL be registered (gnt, select, busy, timeout are flop outputs).
REQ-011 Round-robin order: in IDLE with req != 0, the winner is the first set bit of req, searching from (last+1) mod 4 upward with wrap-around.
  - last is a 2-bit register holding the most recent owner.
REQ-012 Grant transition: in IDLE with any req set, the next edge SHALL make gnt one-hot at the winner, select = winner index, busy = 1, hold_cnt = 0, and the state GRANT.
  - Grant latency is exactly 1 cycle from req sampled high.
REQ-013 In IDLE with req == 0, the block SHALL remain in IDLE; gnt = 0, busy = 0, and select holds its previous value.
REQ-014 In GRANT, hold_cnt SHALL increment by 1 each cycle.
  - hold_cnt is 8 bits wide and never wraps, because it exits at HOLD_MAX-1.
REQ-015 Normal release: in GRANT with req[owner] sampled low, the next edge SHALL go to RELEASE with gnt = 0, last = owner, and timeout = 0.
REQ-016 Forced release: in GRANT with req[owner] high and hold_cnt == HOLD_MAX-1, the next edge SHALL go to RELEASE with gnt = 0, last = owner, and timeout = 1 for exactly one cycle.
REQ-017 If REQ-015 and REQ-016 conditions coincide (req drops on the final cycle), the release is normal and timeout SHALL stay 0.
REQ-018 The owner is held for at most HOLD_MAX cycles with gnt high.
REQ-019 RELEASE SHALL last exactly one cycle (bus turnaround) with gnt = 0, busy = 1, and select unchanged; it then goes to IDLE.
  - Requests are not evaluated in RELEASE.
REQ-020 Requests from non-owners during GRANT SHALL be ignored; there is no preemption.
REQ-021 A requester still high after a forced release competes normally; because of rotation it is lowest priority for the next arbitration.
REQ-022 Simultaneous requests SHALL grant exactly one requester; gnt SHALL never have more than one bit set.
REQ-023 Minimum back-to-back spacing between two grants SHALL be: last GRANT cycle, RELEASE, IDLE, new GRANT.

Reset
REQ-024 rst_n low SHALL immediately, without a clock, force:
  - state = IDLE, gnt = 4'b0000, select = 2'b00, busy = 0, timeout = 0, hold_cnt = 0
  - last = 2'b11, so requester 0 has first priority.
REQ-025 Reset asserted mid-GRANT SHALL drop gnt asynchronously.
  - After rst_n rises, the first arbitration SHALL follow REQ-011 with last = 3.
REQ-026 Deassertion of rst_n is assumed synchronized externally.
  - The first active edge after deassertion may grant.

Verification
REQ-027 Reset, then req = 4'b1111 held -> successive grants 0, 1, 2, 3, 0, each spaced by one RELEASE and one IDLE cycle; select tracks 0, 1, 2, 3, 0.
REQ-028 req = 4'b0100 for 3 cycles, then low -> gnt = 4'b0100 and select = 2 one cycle after req; gnt drops after req falls; RELEASE for one cycle; timeout = 0.
REQ-029 HOLD_MAX = 4, req[1] held high -> gnt[1] high for exactly 4 cycles, then timeout pulses for 1 cycle; req[1] is re-granted after RELEASE and IDLE when it is the only requester.
REQ-030 Owner 2 active, req[0] and req[3] rise mid-grant -> no change to gnt until release; the next winner is 3.
REQ-031 rst_n pulled low mid-GRANT between clock edges -> gnt = 0 and busy = 0 immediately; after release of reset, req = 4'b1010 grants requester 1.
REQ-032 req[owner] falls on the same cycle hold_cnt == HOLD_MAX-1 -> normal release with timeout = 0; the one-hot gnt property is checked by assertion throughout.
